// File: rtl/rsfq_toggle_decoder.sv
// Decodes toggle-encoded SFQ clock/data lines into one bit per RSFQ clock window, buffered in a FIFO.
// Optional RSFQ_DEC_ERRLOG_EN: simulation-only logging of each error-flag rising edge.
module rsfq_toggle_decoder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sfq_clk,
    input  logic                          sfq_q,
    output logic                          bit_valid,
    output logic                          bit_data,
    input  logic                          bit_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [3:0]                    err,
    input  logic                          err_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int unsigned PW = $clog2(SYNC_STAGES + 2);

    localparam logic [PW-1:0] PrimeDone = PW'(SYNC_STAGES + 1);
    localparam logic [GW-1:0] GuardInit = GW'(GUARD_CYCLES);
    localparam logic [LW-1:0] FullLvl   = LW'(FIFO_DEPTH);

    localparam logic StIdle = 1'b0;
    localparam logic StOpen = 1'b1;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d, dat_prev_q, dat_prev_d;
    logic [PW-1:0]          prime_q, prime_d;
    logic                   primed;
    logic                   cp_q, cp_d, qp_q, qp_d;
    logic                   state_q, state_d;
    logic [1:0]             cnt_q, cnt_d, cnt_inc, closing_cnt;
    logic [GW-1:0]          guard_q, guard_d;
    logic                   push_q, push_d, push_bit_q, push_bit_d;
    logic [FIFO_DEPTH-1:0]  mem_q, mem_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   bit_valid_q, bit_valid_d, bit_data_q, bit_data_d;
    logic [3:0]             err_q, err_d;
    logic                   ev_orphan, ev_multi, ev_race, ev_ovf;
    logic                   full, do_push, do_pop;

    // Priming holds off strobes until the synchroniser has filled and prev holds a real sample,
    // so a line already high at reset release is not seen as a pulse.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], sfq_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], sfq_q};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        dat_prev_d = dat_sync_q[SYNC_STAGES-1];
        primed     = (prime_q == PrimeDone);
        prime_d    = primed ? prime_q : prime_q + 1'b1;
        cp_d       = primed & (clk_sync_q[SYNC_STAGES-1] ^ clk_prev_q);
        qp_d       = primed & (dat_sync_q[SYNC_STAGES-1] ^ dat_prev_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        guard_d     = guard_q;
        push_d      = 1'b0;
        push_bit_d  = 1'b0;
        ev_orphan   = 1'b0;
        ev_multi    = 1'b0;
        ev_race     = 1'b0;
        cnt_inc     = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
        closing_cnt = qp_q ? cnt_inc : cnt_q;
        case (state_q)
            StIdle: begin
                ev_orphan = qp_q;
                if (cp_q) begin
                    ev_race = qp_q;
                    state_d = StOpen;
                    cnt_d   = 2'd0;
                    guard_d = GuardInit;
                end
            end
            StOpen: begin
                if (cp_q) begin
                    // A data pulse coincident with the clock belongs to the window being closed.
                    push_d     = 1'b1;
                    push_bit_d = (closing_cnt != 2'd0);
                    ev_multi   = (closing_cnt == 2'd2);
                    ev_race    = qp_q;
                    cnt_d      = 2'd0;
                    guard_d    = GuardInit;
                end else begin
                    if (qp_q) begin
                        cnt_d   = cnt_inc;
                        ev_race = (guard_q != '0);
                    end
                    if (guard_q != '0) guard_d = guard_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // bit_valid_q always mirrors level_q != 0, so popping from an empty FIFO cannot happen.
    always_comb begin
        full     = (level_q == FullLvl);
        do_pop   = bit_valid_q & bit_ready;
        do_push  = push_q & (~full | do_pop);
        ev_ovf   = push_q & full & ~do_pop;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_bit_q;
        wr_ptr_d    = wr_ptr_q + AW'(do_push);
        rd_ptr_d    = rd_ptr_q + AW'(do_pop);
        level_d     = level_q + LW'(do_push) - LW'(do_pop);
        bit_valid_d = (level_d != '0);
        bit_data_d  = (level_d != '0) ? mem_d[rd_ptr_d] : 1'b0;
        err_d       = (err_clr ? 4'b0000 : err_q) | {ev_ovf, ev_race, ev_multi, ev_orphan};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            clk_prev_q  <= 1'b0;
            dat_prev_q  <= 1'b0;
            prime_q     <= '0;
            cp_q        <= 1'b0;
            qp_q        <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            guard_q     <= '0;
            push_q      <= 1'b0;
            push_bit_q  <= 1'b0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            err_q       <= 4'b0000;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            dat_prev_q  <= dat_prev_d;
            prime_q     <= prime_d;
            cp_q        <= cp_d;
            qp_q        <= qp_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            guard_q     <= guard_d;
            push_q      <= push_d;
            push_bit_q  <= push_bit_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            err_q       <= err_d;
        end
    end

    assign bit_valid  = bit_valid_q;
    assign bit_data   = bit_data_q;
    assign fifo_level = level_q;
    assign err        = err_q;

`ifdef RSFQ_DEC_ERRLOG_EN
    always @(posedge clk) begin : errlog
        string flag;
        for (int i = 0; i < 4; i++) begin
            if (rst_n && err_d[i] && !err_q[i]) begin
                case (i)
                    0:       flag = "orphan";
                    1:       flag = "multi";
                    2:       flag = "race";
                    default: flag = "overflow";
                endcase
                $display("Violation of critical timing in module %m; %0t ps. %s", $time, flag);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_rsfq_toggle_decoder.sv
// Bench for rsfq_toggle_decoder: vector table, hand sequences and a randomized window model.
module tb_rsfq_toggle_decoder;

    localparam int GUARD = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sfq_clk = 1'b0;
    logic       sfq_q = 1'b0;
    logic       bit_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       bit_valid;
    logic       bit_data;
    logic [3:0] fifo_level;
    logic [3:0] err;

    always #5 clk = ~clk;

    rsfq_toggle_decoder #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (8),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sfq_clk   (sfq_clk),
        .sfq_q     (sfq_q),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .fifo_level(fifo_level),
        .err       (err),
        .err_clr   (err_clr)
    );

    typedef struct {
        bit         orphan;
        int         nclk;
        int         nq;
        int         first_off;
        bit         same_close;
        int         exp_nbits;
        bit         exp_bit;
        logic [3:0] exp_err;
    } vec_t;

    vec_t       vt[10];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         got[$];
    bit         exp_q[$];
    bit         ca[600];
    bit         qa[600];
    int         cs[16];
    int         exp4[4];
    logic [3:0] exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record a pop using the values that are stable going into the next edge.
    task automatic tick();
        if (bit_valid && bit_ready) got.push_back(bit_data);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(20);
        got.delete();
    endtask

    initial begin
        int n, el, w, s, ncl, g, k, o1, cnt;

        //         orphan nclk nq off same nbits bit err
        vt[0] = '{1'b1, 0, 0, 0,  1'b0, 0, 1'b0, 4'b0001};
        vt[1] = '{1'b0, 2, 0, 0,  1'b0, 1, 1'b0, 4'b0000};
        vt[2] = '{1'b0, 2, 1, 15, 1'b0, 1, 1'b1, 4'b0000};
        vt[3] = '{1'b0, 2, 2, 10, 1'b0, 1, 1'b1, 4'b0010};
        vt[4] = '{1'b0, 2, 3, 5,  1'b0, 1, 1'b1, 4'b0010};
        vt[5] = '{1'b0, 2, 1, 1,  1'b0, 1, 1'b1, 4'b0100};
        vt[6] = '{1'b0, 2, 1, 2,  1'b0, 1, 1'b1, 4'b0000};
        vt[7] = '{1'b0, 2, 0, 0,  1'b1, 1, 1'b1, 4'b0100};
        vt[8] = '{1'b0, 2, 1, 15, 1'b1, 1, 1'b1, 4'b0110};
        vt[9] = '{1'b1, 2, 1, 15, 1'b0, 1, 1'b1, 4'b0001};

        // Clock line already high through reset release must not open a window.
        sfq_clk = 1'b1;
        do_reset();
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_bit_data", 32'(bit_data), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        sfq_q = ~sfq_q;
        ticks(8);
        check("rst_idle_orphan_err", 32'(err), 32'b0001);
        check("rst_idle_no_bit", 32'(got.size()), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            bit_ready = 1'b1;
            if (vt[i].orphan) begin
                sfq_q = ~sfq_q;
                ticks(10);
            end
            if (vt[i].nclk == 2) begin
                sfq_clk = ~sfq_clk;
                el = 0;
                for (int j = 0; j < vt[i].nq; j++) begin
                    w = (j == 0) ? vt[i].first_off : 10;
                    ticks(w);
                    el += w;
                    sfq_q = ~sfq_q;
                end
                ticks(40 - el);
                if (vt[i].same_close) sfq_q = ~sfq_q;
                sfq_clk = ~sfq_clk;
            end
            ticks(15);
            check($sformatf("vec%0d_nbits", i), 32'(got.size()), 32'(vt[i].exp_nbits));
            if (vt[i].exp_nbits == 1 && got.size() == 1)
                check($sformatf("vec%0d_bit", i), 32'(got[0]), 32'(vt[i].exp_bit));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
        end

        // Five clock toggles, data after toggles 1 and 3; latency on the first closing edge.
        do_reset();
        bit_ready = 1'b1;
        n = 0;
        for (int t = 1; t <= 5; t++) begin
            sfq_clk = ~sfq_clk;
            if (t == 2) begin
                n = 0;
                while (!bit_valid && n < 12) begin
                    tick();
                    n++;
                end
                ticks(40 - n);
            end else if (t == 1 || t == 3) begin
                ticks(15);
                sfq_q = ~sfq_q;
                ticks(25);
            end else begin
                ticks(40);
            end
        end
        check("seq_latency", 32'(n), 32'd5);
        exp4 = '{1, 0, 1, 0};
        check("seq_nbits", 32'(got.size()), 32'd4);
        for (int j = 0; j < 4; j++)
            if (j < got.size()) check($sformatf("seq_bit%0d", j), 32'(got[j]), 32'(exp4[j]));
        check("seq_err", 32'(err), 32'd0);

        // Overflow: ten closed windows into an eight-entry FIFO with no consumer.
        do_reset();
        bit_ready = 1'b0;
        for (int t = 0; t < 11; t++) begin
            sfq_clk = ~sfq_clk;
            ticks(8);
        end
        ticks(10);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_err", 32'(err), 32'b1000);
        check("ovf_valid", 32'(bit_valid), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_err_clr", 32'(err), 32'd0);
        got.delete();
        sfq_clk = ~sfq_clk;
        ticks(4);
        bit_ready = 1'b1;
        tick();
        bit_ready = 1'b0;
        check("full_pushpop_level", 32'(fifo_level), 32'd8);
        check("full_pushpop_err", 32'(err), 32'd0);
        check("full_pushpop_pop", 32'(got.size()), 32'd1);
        sfq_clk = ~sfq_clk;
        ticks(4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_vs_event_err", 32'(err), 32'b1000);
        got.delete();
        bit_ready = 1'b1;
        ticks(12);
        check("drain_nbits", 32'(got.size()), 32'd8);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_valid", 32'(bit_valid), 32'd0);
        check("drain_data", 32'(bit_data), 32'd0);

        // Randomized windows against a window-counting model.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int x = 0; x < 600; x++) begin
                ca[x] = 1'b0;
                qa[x] = 1'b0;
            end
            s = 3;
            ncl = $urandom_range(6, 12);
            for (int i = 0; i < ncl; i++) begin
                ca[s] = 1'b1;
                cs[i] = s;
                if (i < ncl - 1) begin
                    g = $urandom_range(6, 16);
                    k = $urandom_range(0, 2);
                    if (k >= 1) begin
                        o1 = $urandom_range(1, g);
                        qa[s + o1] = 1'b1;
                        if (k == 2) qa[s + (o1 % g) + 1] = 1'b1;
                    end
                    s += g;
                end
            end
            exp_q.delete();
            exp_err = 4'b0000;
            for (int i = 0; i < ncl - 1; i++) begin
                cnt = 0;
                for (int d = cs[i] + 1; d <= cs[i + 1]; d++) if (qa[d]) cnt++;
                exp_q.push_back(cnt > 0);
                if (cnt >= 2) exp_err[1] = 1'b1;
            end
            for (int d = 0; d <= s; d++) begin
                if (qa[d]) begin
                    if (d < cs[0]) exp_err[0] = 1'b1;
                    for (int gg = 0; gg <= GUARD; gg++)
                        if (d - gg >= 0 && ca[d - gg]) exp_err[2] = 1'b1;
                end
            end
            for (int x = 0; x <= s; x++) begin
                if (ca[x]) sfq_clk = ~sfq_clk;
                if (qa[x]) sfq_q = ~sfq_q;
                bit_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            bit_ready = 1'b1;
            ticks(20);
            check($sformatf("rand%0d_nbits", r), 32'(got.size()), 32'(exp_q.size()));
            for (int j = 0; j < exp_q.size(); j++)
                if (j < got.size())
                    check($sformatf("rand%0d_bit%0d", r, j), 32'(got[j]), 32'(exp_q[j]));
            check($sformatf("rand%0d_err", r), 32'(err), 32'(exp_err));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
